stdc_multi: RTL and testbench

STDC_MULTI -- requirements
Module: stdc_multi

---
 rtl/stdc_multi_pkg.sv | 31 +++
 rtl/stdc_event_fifo.sv | 74 +++++++
 rtl/stdc_multi.sv | 187 ++++++++++++++++++
 tb/tb_stdc_multi.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/stdc_multi_pkg.sv
// Shared definitions for the multi-channel sampled TDC: event record field
// widths, polarity encoding and width helper functions.
package stdc_multi_pkg;

    localparam int   FINE_W   = 3;
    localparam int   POL_W    = 1;
    localparam int   OVF_W    = 16;
    localparam logic POL_RISE = 1'b1;
    localparam logic POL_FALL = 1'b0;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Channel field width, never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    // Full event record width {channel, polarity, coarse, fine}.
    function automatic int rec_w(input int n, input int cw);
        return chan_w(n) + POL_W + cw + FINE_W;
    endfunction

endpackage

// File: rtl/stdc_event_fifo.sv
// First-word-fall-through event FIFO. The head word is presented on dout_o
// whenever valid_o is high; dout_o reads zero while empty.
module stdc_event_fifo
    import stdc_multi_pkg::*;
#(
    parameter int g_width = 8,
    parameter int g_depth = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_a_i,
    input  logic                      clear_i,
    input  logic                      push_i,
    input  logic [g_width-1:0]        din_i,
    input  logic                      pop_i,
    output logic                      valid_o,
    output logic [g_width-1:0]        dout_o,
    output logic [clog2(g_depth):0]   count_o,
    output logic                      full_o
);

    localparam int AW = clog2(g_depth);

    logic [g_width-1:0] mem_q [g_depth];
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == (AW+1)'(g_depth));
    assign count_o = count_q;
    assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    // Qualify push/pop and compute next pointers and occupancy.
    always_comb begin
        do_push  = push_i & ~full_o & ~clear_i;
        do_pop   = pop_i & valid_o & ~clear_i;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_n_a_i) begin
        if (!rst_n_a_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/stdc_multi.sv
// Multi-channel sampled TDC. Each channel delivers an 8-bit word per cycle
// (bit 0 earliest). Words are registered with their coarse stamp and enables,
// scanned for the earliest enabled edge, parked in a 1-deep holding register
// per channel, and drained round-robin into an event FIFO.
module stdc_multi
    import stdc_multi_pkg::*;
#(
    parameter int g_num_channels = 4,
    parameter int g_coarse_width = 28,
    parameter int g_fifo_depth   = 16
) (
    input  logic                                             clk_sys_i,
    input  logic                                             rst_n_a_i,
    input  logic [8*g_num_channels-1:0]                      samples_i,
    input  logic [g_num_channels-1:0]                        rise_en_i,
    input  logic [g_num_channels-1:0]                        fall_en_i,
    input  logic                                             clear_i,
    input  logic                                             pop_i,
    output logic                                             valid_o,
    output logic [rec_w(g_num_channels, g_coarse_width)-1:0] data_o,
    output logic [clog2(g_fifo_depth):0]                     count_o,
    output logic [OVF_W-1:0]                                 overflow_o
);

    localparam int NCH = g_num_channels;
    localparam int CW  = chan_w(NCH);
    localparam int HW  = POL_W + g_coarse_width + FINE_W;
    localparam int RW  = CW + HW;

    logic [g_coarse_width-1:0]     coarse_q, coarse_d;
    logic [g_coarse_width-1:0]     stamp_q, stamp_d;
    logic [NCH-1:0][7:0]           samp_q, samp_d;
    logic [NCH-1:0]                prev_q, prev_d;
    logic [NCH-1:0]                ren_q, ren_d;
    logic [NCH-1:0]                fen_q, fen_d;

    logic [NCH-1:0][8:0]           seq;
    logic [NCH-1:0][7:0]           hit;
    logic [NCH-1:0]                det_vld;
    logic [NCH-1:0][HW-1:0]        det_rec;

    logic [NCH-1:0]                hold_vld_q, hold_vld_d;
    logic [NCH-1:0][HW-1:0]        hold_rec_q, hold_rec_d;
    logic [CW-1:0]                 ptr_q, ptr_d;
    logic                          gnt_vld;
    logic [CW-1:0]                 gnt_idx;
    logic [NCH-1:0]                drops;

    logic [4:0]                    drop_cnt;
    logic [OVF_W:0]                ovf_sum;
    logic [OVF_W-1:0]              ovf_q, ovf_d;

    logic                          fifo_full;
    logic [RW-1:0]                 push_data;

    // Free-running coarse counter plus the input capture stage: each word is
    // registered with the counter value and enables of its own sampling cycle.
    always_comb begin
        coarse_d = coarse_q + g_coarse_width'(1);
        stamp_d  = coarse_q;
        samp_d   = samples_i;
        ren_d    = rise_en_i;
        fen_d    = fall_en_i;
        for (int c = 0; c < NCH; c++) prev_d[c] = samp_q[c][7];
    end

    // Edge scan over {word, last bit of previous word}; keep the lowest hit.
    always_comb begin
        seq     = '0;
        hit     = '0;
        det_vld = '0;
        det_rec = '0;
        for (int c = 0; c < NCH; c++) begin
            seq[c] = {samp_q[c], prev_q[c]};
            for (int i = 0; i < 8; i++) begin
                hit[c][i] = (ren_q[c] &  seq[c][i+1] & ~seq[c][i]) |
                            (fen_q[c] & ~seq[c][i+1] &  seq[c][i]);
            end
            for (int i = 7; i >= 0; i--) begin
                if (hit[c][i]) begin
                    det_vld[c] = 1'b1;
                    det_rec[c] = {seq[c][i+1], stamp_q, 3'(i)};
                end
            end
        end
    end

    // Round-robin grant: search starts at ptr_q, the channel after the last grant.
    always_comb begin
        int ch;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        ch      = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            ch = (int'(ptr_q) + k) % NCH;
            if (hold_vld_q[ch] && !fifo_full && !clear_i) begin
                gnt_vld = 1'b1;
                gnt_idx = CW'(ch);
            end
        end
    end

    // Holding registers: a grant frees its slot in time for a same-cycle load;
    // a detection into a still-occupied slot is dropped.
    always_comb begin
        hold_vld_d = hold_vld_q;
        hold_rec_d = hold_rec_q;
        ptr_d      = ptr_q;
        drops      = '0;
        if (clear_i) begin
            hold_vld_d = '0;
            ptr_d      = '0;
        end else begin
            if (gnt_vld) begin
                hold_vld_d[gnt_idx] = 1'b0;
                ptr_d = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
            end
            for (int c = 0; c < NCH; c++) begin
                if (det_vld[c]) begin
                    if (hold_vld_d[c]) begin
                        drops[c] = 1'b1;
                    end else begin
                        hold_vld_d[c] = 1'b1;
                        hold_rec_d[c] = det_rec[c];
                    end
                end
            end
        end
    end

    // Saturating drop counter; all drops of one cycle are added at once.
    always_comb begin
        drop_cnt = '0;
        for (int c = 0; c < NCH; c++) drop_cnt = drop_cnt + 5'(drops[c]);
        ovf_sum = {1'b0, ovf_q} + (OVF_W+1)'(drop_cnt);
        if (clear_i)             ovf_d = '0;
        else if (ovf_sum[OVF_W]) ovf_d = '1;
        else                     ovf_d = ovf_sum[OVF_W-1:0];
    end

    // All pipeline, holding and arbiter state.
    always_ff @(posedge clk_sys_i or negedge rst_n_a_i) begin
        if (!rst_n_a_i) begin
            coarse_q   <= '0;
            stamp_q    <= '0;
            samp_q     <= '0;
            prev_q     <= '0;
            ren_q      <= '0;
            fen_q      <= '0;
            hold_vld_q <= '0;
            hold_rec_q <= '0;
            ptr_q      <= '0;
            ovf_q      <= '0;
        end else begin
            coarse_q   <= coarse_d;
            stamp_q    <= stamp_d;
            samp_q     <= samp_d;
            prev_q     <= prev_d;
            ren_q      <= ren_d;
            fen_q      <= fen_d;
            hold_vld_q <= hold_vld_d;
            hold_rec_q <= hold_rec_d;
            ptr_q      <= ptr_d;
            ovf_q      <= ovf_d;
        end
    end

    assign push_data  = {gnt_idx, hold_rec_q[gnt_idx]};
    assign overflow_o = ovf_q;

    stdc_event_fifo #(
        .g_width (RW),
        .g_depth (g_fifo_depth)
    ) u_fifo (
        .clk_i     (clk_sys_i),
        .rst_n_a_i (rst_n_a_i),
        .clear_i   (clear_i),
        .push_i    (gnt_vld),
        .din_i     (push_data),
        .pop_i     (pop_i),
        .valid_o   (valid_o),
        .dout_o    (data_o),
        .count_o   (count_o),
        .full_o    (fifo_full)
    );

endmodule

// File: tb/tb_stdc_multi.sv
// Bench for stdc_multi: directed scenarios plus random traffic, every cycle
// compared against a queue-based event model. A second instance with a 4-bit
// coarse counter exercises the wrap boundary.
module tb_stdc_multi;

    localparam int RW = 2 + 1 + 28 + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   samples = '0;
    logic [3:0]    ren = '0, fen = '0;
    logic          clr = 1'b0, pop = 1'b0;
    logic          valid;
    logic [RW-1:0] data;
    logic [4:0]    count;
    logic [15:0]   ovf;

    logic [31:0]   samples2 = '0;
    logic          valid2;
    logic [9:0]    data2;
    logic [4:0]    count2;
    logic [15:0]   ovf2;

    int total = 0, bad = 0;

    // Reference model state.
    logic [RW-1:0] mq[$];
    bit            hv[4];
    logic [RW-1:0] hr[4];
    int            ptr, movf;
    logic [7:0]    s1w[4];
    bit            s1r[4], s1f[4], prv[4];
    logic [27:0]   s1t, mcoarse;

    always #4 clk = ~clk;

    stdc_multi #(.g_num_channels(4), .g_coarse_width(28), .g_fifo_depth(16)) dut (
        .clk_sys_i(clk), .rst_n_a_i(rst_n), .samples_i(samples), .rise_en_i(ren),
        .fall_en_i(fen), .clear_i(clr), .pop_i(pop), .valid_o(valid), .data_o(data),
        .count_o(count), .overflow_o(ovf));

    stdc_multi #(.g_num_channels(4), .g_coarse_width(4), .g_fifo_depth(16)) dut_w (
        .clk_sys_i(clk), .rst_n_a_i(rst_n), .samples_i(samples2), .rise_en_i(4'b0001),
        .fall_en_i(4'b0000), .clear_i(1'b0), .pop_i(1'b0), .valid_o(valid2), .data_o(data2),
        .count_o(count2), .overflow_o(ovf2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        ptr = 0; movf = 0; s1t = '0; mcoarse = '0;
        for (int c = 0; c < 4; c++) begin
            hv[c] = 0; hr[c] = '0; s1w[c] = '0; s1r[c] = 0; s1f[c] = 0; prv[c] = 0;
        end
    endtask

    // One clock edge of the event flow: word -> detect -> hold -> FIFO.
    task automatic model_step();
        bit            dv[4];
        logic [RW-1:0] det[4];
        logic [8:0]    sq;
        int            gnt;
        for (int c = 0; c < 4; c++) begin
            dv[c] = 0; det[c] = '0;
            sq = {s1w[c], prv[c]};
            for (int i = 0; i < 8; i++) begin
                if (!dv[c] && ((s1r[c] && sq[i+1] && !sq[i]) || (s1f[c] && !sq[i+1] && sq[i]))) begin
                    dv[c] = 1;
                    det[c] = {2'(c), sq[i+1], s1t, 3'(i)};
                end
            end
        end
        if (clr) begin
            mq.delete();
            ptr = 0; movf = 0;
            for (int c = 0; c < 4; c++) hv[c] = 0;
        end else begin
            gnt = -1;
            if (mq.size() < 16)
                for (int k = 0; k < 4; k++)
                    if (gnt < 0 && hv[(ptr + k) % 4]) gnt = (ptr + k) % 4;
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (gnt >= 0) begin
                mq.push_back(hr[gnt]);
                hv[gnt] = 0;
                ptr = (gnt + 1) % 4;
            end
            for (int c = 0; c < 4; c++) begin
                if (dv[c]) begin
                    if (hv[c]) movf = (movf < 65535) ? movf + 1 : 65535;
                    else begin hv[c] = 1; hr[c] = det[c]; end
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            prv[c] = s1w[c][7];
            s1w[c] = samples[8*c +: 8];
            s1r[c] = ren[c];
            s1f[c] = fen[c];
        end
        s1t = mcoarse;
        mcoarse = mcoarse + 28'd1;
    endtask

    task automatic tick();
        logic [RW-1:0] ed;
        @(posedge clk);
        #1;
        model_step();
        ed = (mq.size() != 0) ? mq[0] : '0;
        chk("valid", valid, (mq.size() != 0));
        chk("count", count, mq.size());
        chk("overflow", ovf, movf);
        chk("data", data, ed);
    endtask

    initial begin
        logic [27:0] t;
        model_reset();
        #13;
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;

        // Coarse wrap on the narrow-counter instance: counter value 16 -> 0.
        while (mcoarse != 28'd16) tick();
        samples2 = 32'h0000_00FF;
        tick();
        samples2 = '0;
        tick(); tick();
        chk("wrap_valid", valid2, 1);
        chk("wrap_data", data2, {2'd0, 1'b1, 4'd0, 3'd0});

        // Ch2 rising at coarse 100, fine 4, visible third cycle after the word.
        ren = 4'b0100; fen = '0;
        while (mcoarse != 28'd100) tick();
        samples = 32'h00F0_0000;
        tick();
        samples = '0;
        tick();
        chk("lat_early", valid, 0);
        tick();
        chk("lat_valid", valid, 1);
        chk("ev_ch2", data, {2'd2, 1'b1, 28'd100, 3'd4});
        pop = 1; tick(); pop = 0;

        // Ch0 both polarities, 0x3C: only the earliest (rising, fine 2) reported.
        ren = 4'b0001; fen = 4'b0001;
        t = mcoarse;
        samples = 32'h0000_003C;
        tick();
        samples = '0;
        tick(); tick();
        chk("ev_ch0", data, {2'd0, 1'b1, t, 3'd2});
        tick(); tick();
        chk("ev_ch0_cnt", count, 1);
        pop = 1; tick(); pop = 0;

        // Clear resets the arbiter, then all four channels rise together.
        clr = 1; tick(); clr = 0;
        ren = 4'hF; fen = '0;
        t = mcoarse;
        samples = 32'h0101_0101;
        tick();
        samples = '0;
        repeat (6) tick();
        chk("all4_cnt", count, 4);
        chk("all4_ovf", ovf, 0);
        for (int k = 0; k < 4; k++) begin
            chk("all4_order", data, {2'(k), 1'b1, t, 3'd0});
            pop = 1; tick(); pop = 0;
        end

        // Ch1 toggling with no pops: FIFO fills, later events dropped.
        ren = 4'b0010;
        for (int i = 0; i < 40; i++) begin
            samples = (i % 2 == 0) ? 32'h0000_0F00 : 32'h0;
            tick();
        end
        samples = '0;
        chk("full_cnt", count, 16);
        chk("full_ovf_nz", (ovf != 0), 1);
        pop = 1;
        repeat (11) tick();
        pop = 0;
        clr = 1; tick(); clr = 0;
        chk("clr_valid", valid, 0);
        chk("clr_count", count, 0);
        chk("clr_ovf", ovf, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            samples = (i < 200) ? $urandom : ($urandom & 32'h8181_8181);
            ren = 4'($urandom); fen = 4'($urandom);
            pop = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 39) == 0);
            tick();
        end

        // Asynchronous reset in the middle of traffic.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ovf", ovf, 0);
        samples = '0; ren = '0; fen = '0; pop = 0; clr = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            samples = $urandom;
            ren = 4'($urandom); fen = 4'($urandom);
            pop = $urandom_range(0, 1);
            clr = 1'b0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
